// File: rtl/capture_dump_pkg.sv
// Shared types and helpers for the capture_dump logic-capture block.
// The header-related enum member exists only when CAPTURE_DUMP_HEADER_EN is defined.
package capture_dump_pkg;

  typedef enum logic [2:0] {
    FILL    = 3'd0,
    POST    = 3'd1,
    DUMP_RD = 3'd2,
    DUMP_TX = 3'd3,
    WAIT_HI = 3'd4,
    WAIT_LO = 3'd5
`ifdef CAPTURE_DUMP_HEADER_EN
    , HDR   = 3'd6
`endif
  } state_t;

  localparam logic [7:0] HDR_SYNC = 8'hA5;
  localparam int         HDR_LEN  = 4;

  // Bytes needed to carry one packed RAM word, top byte zero-padded.
  function automatic int calc_bpw(input int mw);
    return (mw + 7) / 8;
  endfunction

endpackage

// File: rtl/capture_ring_ram.sv
// Simple dual-port ring RAM with a registered read port (one-cycle latency).
module capture_ring_ram #(
  parameter int MW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [MW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [MW-1:0] rdata_o
);

  logic [MW-1:0] mem [2**AW];
  logic [MW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/capture_dump.sv
// Multi-channel pre/post-trigger capture into a ring RAM, dumped oldest-first as UART bytes.
// Optional 4-byte dump header is enabled by defining CAPTURE_DUMP_HEADER_EN.
module capture_dump
  import capture_dump_pkg::*;
#(
  parameter int CH         = 1,
  parameter int WORD_W     = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int POST_WORDS = 128,
  parameter int DECIM      = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] sig,
  input  logic          trig,
  output logic [7:0]    tx_dat,
  output logic          tx_start,
  input  logic          tx_busy,
  output logic          dumping,
  output logic          done
);

  localparam int MW    = CH * WORD_W;
  localparam int BPW   = calc_bpw(MW);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int DW    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int SW    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
`ifdef CAPTURE_DUMP_HEADER_EN
  localparam int NB    = (BPW > HDR_LEN) ? BPW : HDR_LEN;
`else
  localparam int NB    = BPW;
`endif
  localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [DW-1:0]     dec_q;
  logic [SW-1:0]     smp_q;
  logic              wstb_q;
  logic [WORD_W-1:0] shreg_q [CH];
  logic [MW-1:0]     word_pack;
  logic              smp_en;

  assign smp_en = (dec_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q  <= '0;
      smp_q  <= '0;
      wstb_q <= 1'b0;
    end else begin
      dec_q  <= (dec_q == DW'(DECIM - 1)) ? '0 : dec_q + 1'b1;
      wstb_q <= smp_en && (smp_q == SW'(WORD_W - 1));
      if (smp_en) smp_q <= (smp_q == SW'(WORD_W - 1)) ? '0 : smp_q + 1'b1;
    end
  end

  // Shift registers carry sample data only; they need no reset.
  always_ff @(posedge clk) begin
    if (smp_en) begin
      for (int c = 0; c < CH; c++) shreg_q[c] <= {shreg_q[c][WORD_W-2:0], sig[c]};
    end
  end

  always_comb begin
    word_pack = '0;
    for (int c = 0; c < CH; c++) word_pack[c*WORD_W +: WORD_W] = shreg_q[c];
  end

  state_t              state_q, state_d;
  logic                trig_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       post_cnt_q, post_cnt_d, words_left_q, words_left_d;
  logic [BW-1:0]       byte_idx_q, byte_idx_d;
  logic                rd_ph_q, rd_ph_d;
  logic [7:0]          tx_dat_q, tx_dat_d;
  logic                tx_start_q, tx_start_d, done_q, done_d;
  logic [MW-1:0]       word_q, word_d, ram_rdata;
  logic [BPW*8-1:0]    word_pad;
  logic [7:0]          data_byte;
  logic                ram_we;
`ifdef CAPTURE_DUMP_HEADER_EN
  logic                hdr_q, hdr_d;
  logic [7:0]          hdr_byte;
`endif

  capture_ring_ram #(.MW(MW), .AW(DEPTH_LOG2)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (word_pack),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  assign word_pad  = (BPW*8)'(word_q);
  assign data_byte = 8'(word_pad >> {byte_idx_q, 3'b000});
  assign ram_we    = wstb_q && ((state_q == FILL) || (state_q == POST));

`ifdef CAPTURE_DUMP_HEADER_EN
  always_comb begin
    case (byte_idx_q)
      BW'(0):  hdr_byte = HDR_SYNC;
      BW'(1):  hdr_byte = 8'(CH);
      BW'(2):  hdr_byte = 8'(WORD_W);
      default: hdr_byte = 8'(DEPTH_LOG2);
    endcase
  end
`endif

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = ram_we ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    post_cnt_d   = post_cnt_q;
    words_left_d = words_left_q;
    byte_idx_d   = byte_idx_q;
    rd_ph_d      = rd_ph_q;
    tx_dat_d     = tx_dat_q;
    tx_start_d   = 1'b0;
    done_d       = 1'b0;
    word_d       = word_q;
`ifdef CAPTURE_DUMP_HEADER_EN
    hdr_d        = hdr_q;
`endif
    case (state_q)
      FILL: begin
        if (trig && !trig_q) begin
          state_d    = POST;
          post_cnt_d = '0;
        end
      end
      POST: begin
        if (ram_we) begin
          post_cnt_d = post_cnt_q + 1'b1;
          if (post_cnt_d == CW'(POST_WORDS)) begin
            // The slot after the final post-trigger write holds the oldest word.
            rd_ptr_d     = wr_ptr_q + 1'b1;
            words_left_d = CW'(DEPTH);
            byte_idx_d   = '0;
            rd_ph_d      = 1'b0;
`ifdef CAPTURE_DUMP_HEADER_EN
            hdr_d        = 1'b1;
            state_d      = HDR;
`else
            state_d      = DUMP_RD;
`endif
          end
        end
      end
`ifdef CAPTURE_DUMP_HEADER_EN
      HDR: begin
        if (!tx_busy) begin
          tx_dat_d   = hdr_byte;
          tx_start_d = 1'b1;
          state_d    = WAIT_HI;
        end
      end
`endif
      DUMP_RD: begin
        if (!rd_ph_q) begin
          rd_ph_d = 1'b1;
        end else begin
          rd_ph_d    = 1'b0;
          word_d     = ram_rdata;
          byte_idx_d = '0;
          state_d    = DUMP_TX;
        end
      end
      DUMP_TX: begin
        if (!tx_busy) begin
          tx_dat_d   = data_byte;
          tx_start_d = 1'b1;
          state_d    = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
`ifdef CAPTURE_DUMP_HEADER_EN
          if (hdr_q) begin
            if (byte_idx_q != BW'(HDR_LEN - 1)) begin
              byte_idx_d = byte_idx_q + 1'b1;
              state_d    = HDR;
            end else begin
              hdr_d      = 1'b0;
              byte_idx_d = '0;
              state_d    = DUMP_RD;
            end
          end else
`endif
          if (byte_idx_q != BW'(BPW - 1)) begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = DUMP_TX;
          end else begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            words_left_d = words_left_q - 1'b1;
            if (words_left_d == '0) begin
              done_d  = 1'b1;
              state_d = FILL;
            end else begin
              state_d = DUMP_RD;
            end
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      trig_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      post_cnt_q   <= '0;
      words_left_q <= '0;
      byte_idx_q   <= '0;
      rd_ph_q      <= 1'b0;
      tx_dat_q     <= '0;
      tx_start_q   <= 1'b0;
      done_q       <= 1'b0;
`ifdef CAPTURE_DUMP_HEADER_EN
      hdr_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      trig_q       <= trig;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      post_cnt_q   <= post_cnt_d;
      words_left_q <= words_left_d;
      byte_idx_q   <= byte_idx_d;
      rd_ph_q      <= rd_ph_d;
      tx_dat_q     <= tx_dat_d;
      tx_start_q   <= tx_start_d;
      done_q       <= done_d;
`ifdef CAPTURE_DUMP_HEADER_EN
      hdr_q        <= hdr_d;
`endif
    end
  end

  always_ff @(posedge clk) word_q <= word_d;

  assign tx_dat   = tx_dat_q;
  assign tx_start = tx_start_q;
  assign done     = done_q;
  assign dumping  = (state_q != FILL) && (state_q != POST);

endmodule

// File: tb/tb_capture_dump.sv
// Directed bench for capture_dump: CH=3, WORD_W=4, 16-word ring, 8 post-trigger words, DECIM=2.
module tb_capture_dump;

  localparam int CH = 3, WORD_W = 4, DEPTH_LOG2 = 4, POST_WORDS = 8, DECIM = 2;
  localparam int NWORDS = 16, NBYTES = 32;
`ifdef CAPTURE_DUMP_HEADER_EN
  localparam int HDRN = 4;
`else
  localparam int HDRN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, trig, tx_busy, tx_start, dumping, done;
  logic [CH-1:0] sig;
  logic [7:0]    tx_dat;

  int checks = 0, errors = 0;
  int start_cnt = 0, done_cnt = 0, busy_left = 0;
  logic [7:0] bq[$];

  always #5 clk = ~clk;

  capture_dump #(.CH(CH), .WORD_W(WORD_W), .DEPTH_LOG2(DEPTH_LOG2),
                 .POST_WORDS(POST_WORDS), .DECIM(DECIM)) dut (
    .clk(clk), .rst(rst), .sig(sig), .trig(trig), .tx_dat(tx_dat),
    .tx_start(tx_start), .tx_busy(tx_busy), .dumping(dumping), .done(done)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int get_byte(input int i);
    if (i < bq.size()) return int'(bq[i]);
    return -1;
  endfunction

  // acia_tx model: busy for 3 cycles after each start; also flags starts issued while busy.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        chk("start_while_busy", int'(tx_busy), 0);
        bq.push_back(tx_dat);
        start_cnt++;
        tx_busy   = 1'b1;
        busy_left = 3;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end
      if (done) done_cnt++;
    end
  end

  task automatic pulse_trig();
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  task automatic wait_done(input int n0, input string tag);
    int k = 0;
    while (done_cnt == n0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    chk(tag, done_cnt - n0, 1);
  endtask

  task automatic wait_starts(input int target, input string tag);
    int k = 0;
    while (start_cnt < target && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, int'(start_cnt >= target), 1);
  endtask

  task automatic chk_header();
`ifdef CAPTURE_DUMP_HEADER_EN
    chk("hdr_sync", get_byte(0), 8'hA5);
    chk("hdr_ch",   get_byte(1), CH);
    chk("hdr_ww",   get_byte(2), WORD_W);
    chk("hdr_dl",   get_byte(3), DEPTH_LOG2);
`endif
  endtask

  task automatic chk_words(input string tag, input int lo, input int hi,
                           input int b0, input int b1);
    for (int w = lo; w <= hi; w++) begin
      chk({tag, "_lo"}, get_byte(HDRN + 2*w),     b0);
      chk({tag, "_hi"}, get_byte(HDRN + 2*w + 1), b1);
    end
  endtask

  initial begin
    int s0, d0;
    rst = 1'b1; trig = 1'b0; sig = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_dumping",  int'(dumping), 0);
    chk("rst_done",     int'(done), 0);
    chk("rst_tx_dat",   int'(tx_dat), 0);
    rst = 1'b0;

    // A: ch0=1, ch1=0, ch2=1 -> word 0xF0F; retriggers in POST and DUMP are ignored.
    sig = 3'b101;
    repeat (200) @(negedge clk);
    bq.delete();
    s0 = start_cnt; d0 = done_cnt;
    pulse_trig();
    repeat (20) @(negedge clk);
    chk("post_no_dump", int'(dumping), 0);
    pulse_trig();
    wait_starts(s0 + 1, "a_first_start");
    chk("a_dumping_high", int'(dumping), 1);
    wait_starts(s0 + 3, "a_third_start");
    pulse_trig();
    wait_done(d0, "a_done_once");
    chk("a_byte_count", bq.size(), HDRN + NBYTES);
    chk("a_dumping_low", int'(dumping), 0);
    chk_header();
    chk_words("a_word", 0, NWORDS - 1, 8'h0F, 8'h0F);
    s0 = start_cnt;
    repeat (150) @(negedge clk);
    chk("a_no_queued_trig", start_cnt, s0);

    // B: zeros, then all channels high from the trigger instant -> marker at word 8 +-1.
    sig = 3'b000;
    repeat (200) @(negedge clk);
    bq.delete();
    d0 = done_cnt;
    sig = 3'b111;
    pulse_trig();
    wait_done(d0, "b_done_once");
    chk("b_byte_count", bq.size(), HDRN + NBYTES);
    chk_header();
    chk_words("b_pre", 0, 7, 8'h00, 8'h00);
    chk_words("b_post", 9, NWORDS - 1, 8'hFF, 8'h0F);

    // C: reset after the tenth byte of a dump aborts it.
    sig = 3'b010;
    repeat (200) @(negedge clk);
    bq.delete();
    s0 = start_cnt;
    pulse_trig();
    wait_starts(s0 + 10, "c_ten_starts");
    rst = 1'b1;
    @(negedge clk);
    chk("c_rst_tx_start", int'(tx_start), 0);
    chk("c_rst_dumping",  int'(dumping), 0);
    chk("c_rst_done",     int'(done), 0);
    chk("c_rst_tx_dat",   int'(tx_dat), 0);
    @(negedge clk);
    rst = 1'b0;
    s0 = start_cnt; d0 = done_cnt;
    repeat (150) @(negedge clk);
    chk("c_no_start_after_rst", start_cnt, s0);
    chk("c_no_done_after_rst",  done_cnt, d0);

    // D: fresh capture after reset, ch1 only -> word 0x0F0.
    repeat (100) @(negedge clk);
    bq.delete();
    d0 = done_cnt;
    pulse_trig();
    wait_done(d0, "d_done_once");
    chk("d_byte_count", bq.size(), HDRN + NBYTES);
    chk_header();
    chk_words("d_word", 0, NWORDS - 1, 8'hF0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
